serdes_frame_link: RTL

//   Parametrised serial link endpoint: TX framer/serialiser plus RX deframer/deserialiser with error counting.

---
 rtl/serdes_frame_link_if.sv | 34 +++
 rtl/serdes_frame_link.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_frame_link_if.sv
// Purpose: bundles the user-side handshake and the serial line pins of serdes_frame_link.
// Signals:
//   tx_data/tx_valid/tx_ready       word handshake into the transmitter
//   dataout/datain                  serial line out / in, idle high
//   rx_data/rx_valid                last good received word, 1-cycle update pulse
//   rx_parity_err/rx_frame_err      1-cycle error pulses
//   err_count/err_clear             saturating bad-frame counter and its synchronous clear
// Modports: slave = link endpoint, master = user logic / line driver.
interface serdes_frame_link_if #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned ERR_CNT_W = 4
);
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 dataout;
  logic                 datain;
  logic [DATA_W-1:0]    rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_clear;

  modport slave (
    input  tx_data, tx_valid, datain, err_clear,
    output tx_ready, dataout, rx_data, rx_valid, rx_parity_err, rx_frame_err, err_count
  );

  modport master (
    output tx_data, tx_valid, datain, err_clear,
    input  tx_ready, dataout, rx_data, rx_valid, rx_parity_err, rx_frame_err, err_count
  );
endinterface

// File: rtl/serdes_frame_link.sv
// Purpose: single-wire serial link endpoint. TX frames and serialises a word
// (start 0, payload LSB first, optional even parity, stop 1); RX synchronises the
// line, deframes, checks parity/stop and counts bad frames. One bit per clkin cycle.
// Ports:
//   clkin  clock, all logic on rising edge
//   rstin  asynchronous active-high reset
//   link   serdes_frame_link_if.slave: tx handshake, serial pins, rx word/pulses, error counter
module serdes_frame_link #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned ERR_CNT_W = 4
) (
  input logic                 clkin,
  input logic                 rstin,
  serdes_frame_link_if.slave  link
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  // TX state names describe the bit currently on dataout
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  // RX state names describe the bit expected on the synchronised line
  localparam logic [2:0] RX_BREAK  = 3'd0;
  localparam logic [2:0] RX_IDLE   = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  logic [2:0]        tx_state, tx_state_nxt;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_nxt;
  logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
  logic              tx_par, tx_par_nxt;
  logic              dataout_q, dataout_nxt;
  logic              tx_ready_q, tx_ready_nxt;

  logic                 sync1, sync2;
  logic [2:0]           rx_state, rx_state_nxt;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_nxt;
  logic [DATA_W-1:0]    rx_shift, rx_shift_nxt;
  logic                 rx_par, rx_par_nxt;
  logic [DATA_W-1:0]    rx_data_q, rx_data_nxt;
  logic                 rx_valid_q, rx_valid_nxt;
  logic                 rx_perr_q, rx_perr_nxt;
  logic                 rx_ferr_q, rx_ferr_nxt;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_nxt;
  logic                 rx_par_bad;

  // Running parity over payload and parity bit must be zero for even parity
  assign rx_par_bad = (PARITY_EN != 0) && rx_par;

  // State and output registers; line-side flops reset to the idle level
  always_ff @(posedge clkin or posedge rstin) begin
    if (rstin) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      dataout_q   <= 1'b1;
      tx_ready_q  <= 1'b1;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      rx_state    <= RX_BREAK;
      rx_cnt      <= '0;
      rx_shift    <= '0;
      rx_par      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      tx_state    <= tx_state_nxt;
      tx_cnt      <= tx_cnt_nxt;
      tx_shift    <= tx_shift_nxt;
      tx_par      <= tx_par_nxt;
      dataout_q   <= dataout_nxt;
      tx_ready_q  <= tx_ready_nxt;
      sync1       <= link.datain;
      sync2       <= sync1;
      rx_state    <= rx_state_nxt;
      rx_cnt      <= rx_cnt_nxt;
      rx_shift    <= rx_shift_nxt;
      rx_par      <= rx_par_nxt;
      rx_data_q   <= rx_data_nxt;
      rx_valid_q  <= rx_valid_nxt;
      rx_perr_q   <= rx_perr_nxt;
      rx_ferr_q   <= rx_ferr_nxt;
      err_count_q <= err_count_nxt;
    end
  end

  // TX next state: word and its parity are latched at accept, so later tx_data changes are ignored
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    dataout_nxt  = 1'b1;
    tx_ready_nxt = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_ready_nxt = 1'b1;
        if (link.tx_valid && tx_ready_q) begin
          tx_shift_nxt = link.tx_data;
          tx_par_nxt   = ^link.tx_data;
          tx_state_nxt = TX_START;
          dataout_nxt  = 1'b0;
          tx_ready_nxt = 1'b0;
        end
      end
      TX_START: begin
        tx_state_nxt = TX_DATA;
        tx_cnt_nxt   = '0;
        dataout_nxt  = tx_shift[0];
        tx_shift_nxt = tx_shift >> 1;
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          if (PARITY_EN != 0) begin
            tx_state_nxt = TX_PARITY;
            dataout_nxt  = tx_par;
          end else begin
            tx_state_nxt = TX_STOP;
          end
        end else begin
          tx_cnt_nxt   = tx_cnt + CNT_W'(1);
          dataout_nxt  = tx_shift[0];
          tx_shift_nxt = tx_shift >> 1;
        end
      end
      TX_PARITY: begin
        tx_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        tx_state_nxt = TX_IDLE;
        tx_ready_nxt = 1'b1;
      end
      default: begin
        tx_state_nxt = TX_IDLE;
        tx_ready_nxt = 1'b1;
      end
    endcase
  end

  // RX next state: BREAK holds off start detection until the line has returned high
  always_comb begin
    rx_state_nxt  = rx_state;
    rx_cnt_nxt    = rx_cnt;
    rx_shift_nxt  = rx_shift;
    rx_par_nxt    = rx_par;
    rx_data_nxt   = rx_data_q;
    rx_valid_nxt  = 1'b0;
    rx_perr_nxt   = 1'b0;
    rx_ferr_nxt   = 1'b0;
    err_count_nxt = err_count_q;
    case (rx_state)
      RX_BREAK: begin
        if (sync2) rx_state_nxt = RX_IDLE;
      end
      RX_IDLE: begin
        if (!sync2) begin
          rx_state_nxt = RX_DATA;
          rx_cnt_nxt   = '0;
          rx_par_nxt   = 1'b0;
        end
      end
      RX_DATA: begin
        rx_shift_nxt = (rx_shift >> 1) | (DATA_W'(sync2) << (DATA_W - 1));
        rx_par_nxt   = rx_par ^ sync2;
        if (rx_cnt == CNT_LAST) begin
          rx_state_nxt = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        rx_par_nxt   = rx_par ^ sync2;
        rx_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        rx_perr_nxt = rx_par_bad;
        if (sync2) begin
          rx_state_nxt = RX_IDLE;
          if (!rx_par_bad) begin
            rx_data_nxt  = rx_shift;
            rx_valid_nxt = 1'b1;
          end
        end else begin
          rx_ferr_nxt  = 1'b1;
          rx_state_nxt = RX_BREAK;
        end
        // One increment per bad frame, even when both flags fire
        if ((rx_par_bad || !sync2) && (err_count_q != ERR_MAX)) begin
          err_count_nxt = err_count_q + ERR_CNT_W'(1);
        end
      end
      default: begin
        rx_state_nxt = RX_BREAK;
      end
    endcase
    // Clear takes priority over a coincident increment
    if (link.err_clear) err_count_nxt = '0;
  end

  assign link.dataout       = dataout_q;
  assign link.tx_ready      = tx_ready_q;
  assign link.rx_data       = rx_data_q;
  assign link.rx_valid      = rx_valid_q;
  assign link.rx_parity_err = rx_perr_q;
  assign link.rx_frame_err  = rx_ferr_q;
  assign link.err_count     = err_count_q;

endmodule
